// File: rtl/irq_timer_pkg.sv
// Shared constants and types for irq_timer_controller: register map, IACK function code,
// bus handshake state encoding and the IPL priority helper.
package irq_timer_pkg;

    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_STATUS     = 3'd1;
    localparam logic [2:0] REG_SEL        = 3'd2;
    localparam logic [2:0] REG_RELOAD_HI  = 3'd3;
    localparam logic [2:0] REG_RELOAD_MID = 3'd4;
    localparam logic [2:0] REG_RELOAD_LO  = 3'd5;
    localparam logic [2:0] REG_AVEC       = 3'd6;
    localparam logic [2:0] REG_ID         = 3'd7;

    localparam logic [7:0] ID_BASE    = 8'hA0;
    localparam logic [7:0] AVEC_RESET = 8'h40;
    localparam logic [2:0] FC_IACK    = 3'b111;

    typedef enum logic [1:0] {
        BUS_IDLE     = 2'd0,
        BUS_REG_ACK  = 2'd1,
        BUS_IACK_ACK = 2'd2
    } bus_state_t;

    // Highest asserted request level, 0 when nothing is requesting.
    function automatic logic [2:0] highest_level(input logic [7:1] req);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int l = 1; l <= 7; l++) begin
            if (req[l]) lvl = 3'(l);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/irq_timer_channel.sv
// One periodic timer: loads on the enable rising edge, counts down while enabled and
// emits a one-cycle fire strobe when the count expires, reloading in the same cycle.
module irq_timer_channel #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] reload,
    output logic             fire
);

    logic [WIDTH-1:0] count;
    logic             enable_q;

    // A zero count reloads without firing, so RELOAD=0 never produces a fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q) begin
                count <= reload;
            end else if (enable) begin
                if (count <= WIDTH'(1)) count <= reload;
                else                    count <= count - WIDTH'(1);
            end
        end
    end

    assign fire = enable && enable_q && (count == WIDTH'(1));

endmodule

// File: rtl/irq_timer_controller.sv
// 68000-side interrupt/timer block: periodic timers, IPL encoder, IACK autovectoring and
// register window. Optional bus watchdog driving BERR_n is built when BUS_WATCHDOG_EN is defined.
module irq_timer_controller
    import irq_timer_pkg::*;
#(
    parameter int NUM_TIMERS  = 2,
    parameter int TIMER_WIDTH = 24,
    parameter int TIMER_IPL   = 6,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       CS_n,
    input  logic       AS_n,
    input  logic       LDS_n,
    input  logic       RW,
    input  logic [2:0] FC,
    input  logic [2:0] ADDR,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    input  logic [6:0] IRQ_n,
    input  logic       DTACK_IN_n,
    output logic [2:0] IPL_n,
    output logic       DTACK_n,
    output logic       VPA_n,
    output logic       BERR_n
);

    localparam int SEL_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

    // Handshake: a request is sampled on a rising edge; the acknowledge (DTACK_n or VPA_n)
    // asserts on that edge and holds until AS_n is sampled high, then releases on that edge.
    bus_state_t bus_state, bus_state_d;
    logic       reg_req, iack_req, reg_start, iack_start, wr_en;

    logic [NUM_TIMERS-1:0]  ctrl_q, pend_q, pend_d, fire, iack_clear;
    logic [SEL_W-1:0]       sel_q;
    logic [7:0]             stage_hi, stage_mid;
    logic [TIMER_WIDTH-1:0] reload_q [NUM_TIMERS];
    logic [7:1]             avec_q;
    logic [7:0]             avec_full;
    logic                   berr_flag_q, wdog_fire;
    logic [23:0]            sel_reload;
    logic [7:0]             rd_data;
    logic [7:1]             level_req;
    logic [2:0]             level, ipl_n_q;
    logic [7:0]             data_out_q;
    logic                   data_oe_q;

    assign avec_full = {avec_q, 1'b0};
    assign reg_req   = !CS_n && !AS_n && !LDS_n && (FC != FC_IACK);
    assign iack_req  = (FC == FC_IACK) && !AS_n && avec_full[ADDR];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) bus_state <= BUS_IDLE;
        else        bus_state <= bus_state_d;
    end

    always_comb begin
        bus_state_d = bus_state;
        reg_start   = 1'b0;
        iack_start  = 1'b0;
        case (bus_state)
            BUS_IDLE: begin
                if (reg_req) begin
                    bus_state_d = BUS_REG_ACK;
                    reg_start   = 1'b1;
                end else if (iack_req) begin
                    bus_state_d = BUS_IACK_ACK;
                    iack_start  = 1'b1;
                end
            end
            BUS_REG_ACK, BUS_IACK_ACK: begin
                if (AS_n) bus_state_d = BUS_IDLE;
            end
            default: bus_state_d = BUS_IDLE;
        endcase
    end

    assign wr_en   = reg_start && !RW;
    assign DTACK_n = (bus_state != BUS_REG_ACK);
    assign VPA_n   = (bus_state != BUS_IACK_ACK);

    always_comb begin
        sel_reload = '0;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (sel_q == SEL_W'(k)) sel_reload[TIMER_WIDTH-1:0] = reload_q[k];
        end
    end

    always_comb begin
        rd_data = '0;
        case (ADDR)
            REG_CTRL:       rd_data[NUM_TIMERS-1:0] = ctrl_q;
            REG_STATUS: begin
                rd_data[NUM_TIMERS-1:0] = pend_q;
                rd_data[7]              = berr_flag_q;
            end
            REG_SEL:        rd_data[SEL_W-1:0] = sel_q;
            REG_RELOAD_HI:  rd_data = sel_reload[23:16];
            REG_RELOAD_MID: rd_data = sel_reload[15:8];
            REG_RELOAD_LO:  rd_data = sel_reload[7:0];
            REG_AVEC:       rd_data = avec_full;
            REG_ID:         rd_data = ID_BASE | 8'(NUM_TIMERS);
            default:        rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
        end else if (reg_start) begin
            data_out_q <= rd_data;
            data_oe_q  <= RW;
        end else if (bus_state == BUS_REG_ACK && AS_n) begin
            data_oe_q  <= 1'b0;
        end
    end

    assign DATA_OUT = data_out_q;
    assign DATA_OE  = data_oe_q;

    // IACK at the timer level retires only the lowest-index pending timer; a fire in the
    // same cycle as a clear leaves the bit set.
    always_comb begin
        iack_clear = pend_q & (~pend_q + NUM_TIMERS'(1));
        pend_d     = pend_q;
        if (wr_en && ADDR == REG_STATUS) pend_d = pend_d & ~DATA_IN[NUM_TIMERS-1:0];
        if (iack_start && ADDR == 3'(TIMER_IPL)) pend_d = pend_d & ~iack_clear;
        pend_d = pend_d | fire;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ctrl_q      <= '0;
            pend_q      <= '0;
            sel_q       <= '0;
            stage_hi    <= '0;
            stage_mid   <= '0;
            avec_q      <= AVEC_RESET[7:1];
            berr_flag_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (wr_en) begin
                case (ADDR)
                    REG_CTRL:       ctrl_q    <= DATA_IN[NUM_TIMERS-1:0];
                    REG_SEL:        sel_q     <= (NUM_TIMERS > 1) ? DATA_IN[SEL_W-1:0] : '0;
                    REG_RELOAD_HI:  stage_hi  <= DATA_IN;
                    REG_RELOAD_MID: stage_mid <= DATA_IN;
                    REG_AVEC:       avec_q    <= DATA_IN[7:1];
                    default: ;
                endcase
            end
            if (wdog_fire)
                berr_flag_q <= 1'b1;
            else if (wr_en && ADDR == REG_STATUS && DATA_IN[7])
                berr_flag_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int k = 0; k < NUM_TIMERS; k++) reload_q[k] <= '0;
        end else if (wr_en && ADDR == REG_RELOAD_LO) begin
            for (int k = 0; k < NUM_TIMERS; k++) begin
                if (sel_q == SEL_W'(k))
                    reload_q[k] <= TIMER_WIDTH'({stage_hi, stage_mid, DATA_IN});
            end
        end
    end

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_timer
        irq_timer_channel #(.WIDTH(TIMER_WIDTH)) u_channel (
            .clk    (CLK),
            .rst_n  (RST_n),
            .enable (ctrl_q[k]),
            .reload (reload_q[k]),
            .fire   (fire[k])
        );
    end

    always_comb begin
        level_req = ~IRQ_n;
        if (|pend_q) level_req[TIMER_IPL] = 1'b1;
        level = highest_level(level_req);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) ipl_n_q <= 3'b111;
        else        ipl_n_q <= ~level;
    end

    assign IPL_n = ipl_n_q;

`ifdef BUS_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              berr_n_q, wdog_run;

    // Counts only while a cycle is outstanding with no acknowledge from anyone.
    assign wdog_run  = !AS_n && berr_n_q && DTACK_IN_n && VPA_n && DTACK_n;
    assign wdog_fire = wdog_run && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wdog_cnt <= '0;
            berr_n_q <= 1'b1;
        end else if (AS_n) begin
            wdog_cnt <= '0;
            berr_n_q <= 1'b1;
        end else if (wdog_run) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
            if (wdog_fire) berr_n_q <= 1'b0;
        end
    end

    assign BERR_n = berr_n_q;
`else
    localparam int WDOG_CYCLES_UNUSED = WDOG_CYCLES;
    logic dtack_in_unused;

    assign dtack_in_unused = DTACK_IN_n;
    assign wdog_fire       = 1'b0;
    assign BERR_n          = 1'b1;
`endif

endmodule

// File: tb/tb_irq_timer_controller.sv
// Self-checking bench for irq_timer_controller (NUM_TIMERS=2, TIMER_IPL=6, WDOG_CYCLES=16).
module tb_irq_timer_controller;
    import irq_timer_pkg::*;

    logic       CLK, RST_n, CS_n, AS_n, LDS_n, RW, DTACK_IN_n;
    logic [2:0] FC, ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DATA_OE, DTACK_n, VPA_n, BERR_n;
    logic [6:0] IRQ_n;
    logic [2:0] IPL_n;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    irq_timer_controller #(
        .NUM_TIMERS(2), .TIMER_WIDTH(24), .TIMER_IPL(6), .WDOG_CYCLES(16)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .CS_n(CS_n), .AS_n(AS_n), .LDS_n(LDS_n), .RW(RW),
        .FC(FC), .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
        .IRQ_n(IRQ_n), .DTACK_IN_n(DTACK_IN_n), .IPL_n(IPL_n), .DTACK_n(DTACK_n),
        .VPA_n(VPA_n), .BERR_n(BERR_n)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 no acknowledge, 1 DTACK_n, 2 VPA_n
    task automatic bus_cycle(input logic rw, input logic [2:0] fc, input logic [2:0] addr,
                             input logic [7:0] wdata, input logic [7:0] exp_rd,
                             input string tag, output logic [1:0] kind);
        logic [7:0] exp_v;
        logic       is_reg, released;
        is_reg = (fc != 3'b111);
        @(negedge CLK);
        CS_n = !is_reg; AS_n = 1'b0; LDS_n = 1'b0; RW = rw; FC = fc; ADDR = addr; DATA_IN = wdata;
        if (is_reg && rw) exp_q.push_back(exp_rd);
        kind = 2'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (!DTACK_n || !VPA_n) begin
                kind = !DTACK_n ? 2'd1 : 2'd2;
                break;
            end
        end
        check({tag, " ack exclusive"}, 32'(!DTACK_n && !VPA_n), 32'd0);
        if (is_reg && rw) begin
            exp_v = exp_q.pop_front();
            if (kind == 2'd1) check(tag, 32'(DATA_OUT), 32'(exp_v));
            else              check({tag, " no dtack"}, 32'(kind), 32'd1);
        end
        if (kind == 2'd1) check({tag, " data_oe"}, 32'(DATA_OE), 32'(rw));
        AS_n = 1'b1; CS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1; FC = 3'b101;
        if (kind != 2'd0) begin
            released = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge CLK);
                if (DTACK_n && VPA_n) begin
                    released = 1'b1;
                    break;
                end
            end
            check({tag, " release"}, 32'(released), 32'd1);
        end
    endtask

    task automatic reg_write(input logic [2:0] addr, input logic [7:0] data, input string tag);
        logic [1:0] k;
        bus_cycle(1'b0, 3'b101, addr, data, 8'h00, tag, k);
        check({tag, " ack"}, 32'(k), 32'd1);
    endtask

    task automatic reg_read(input logic [2:0] addr, input logic [7:0] exp, input string tag);
        logic [1:0] k;
        bus_cycle(1'b1, 3'b101, addr, 8'h00, exp, tag, k);
    endtask

    task automatic iack(input logic [2:0] lvl, input logic expect_vpa, input string tag);
        logic [1:0] k;
        bus_cycle(1'b1, 3'b111, lvl, 8'h00, 8'h00, tag, k);
        check(tag, 32'(k), expect_vpa ? 32'd2 : 32'd0);
    endtask

    task automatic wait_ipl(input logic [2:0] val, input int limit, input string tag, output int at);
        logic found;
        found = 1'b0;
        at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (IPL_n == val) begin
                found = 1'b1;
                at = cyc;
                break;
            end
        end
        check({tag, " seen"}, 32'(found), 32'd1);
    endtask

    int t1, t2, f, c0;
    logic seen;

    initial begin
        RST_n = 1'b0; CS_n = 1'b1; AS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1; FC = 3'b101;
        ADDR = 3'd0; DATA_IN = 8'h00; IRQ_n = 7'h7F; DTACK_IN_n = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST_n = 1'b1;

        // Reset asserted mid-cycle while a request is up and a register cycle is acknowledged
        IRQ_n = 7'b1111110;
        repeat (3) @(negedge CLK);
        check("ipl level1", 32'(IPL_n), 32'(3'b110));
        CS_n = 1'b0; AS_n = 1'b0; LDS_n = 1'b0; RW = 1'b1; ADDR = REG_ID;
        @(negedge CLK);
        check("pre-reset dtack", 32'(DTACK_n), 32'd0);
        check("pre-reset id", 32'(DATA_OUT), 32'hA2);
        #2 RST_n = 1'b0;
        #1;
        check("rst ipl", 32'(IPL_n), 32'(3'b111));
        check("rst dtack", 32'(DTACK_n), 32'd1);
        check("rst vpa", 32'(VPA_n), 32'd1);
        check("rst berr", 32'(BERR_n), 32'd1);
        check("rst data_oe", 32'(DATA_OE), 32'd0);
        check("rst data_out", 32'(DATA_OUT), 32'd0);
        CS_n = 1'b1; AS_n = 1'b1; LDS_n = 1'b1; IRQ_n = 7'h7F;
        @(negedge CLK) RST_n = 1'b1;

        reg_read(REG_ID, 8'hA2, "id");
        reg_read(REG_CTRL, 8'h00, "ctrl reset");
        reg_read(REG_STATUS, 8'h00, "status reset");
        reg_read(REG_SEL, 8'h00, "sel reset");
        reg_read(REG_AVEC, 8'h40, "avec reset");

        // Timer 0 period 20, IACK retirement and re-fire spacing
        reg_write(REG_SEL, 8'h00, "sel0");
        reg_write(REG_RELOAD_HI, 8'h00, "rl hi");
        reg_write(REG_RELOAD_MID, 8'h00, "rl mid");
        reg_write(REG_RELOAD_LO, 8'd20, "rl lo 20");
        reg_write(REG_CTRL, 8'h01, "ctrl t0");
        wait_ipl(3'b001, 60, "first fire ipl", t1);
        reg_read(REG_STATUS, 8'h01, "status t0 pend");
        iack(3'd6, 1'b1, "iack6 t0");
        check("ipl after iack", 32'(IPL_n), 32'(3'b111));
        wait_ipl(3'b001, 40, "second fire ipl", t2);
        check("period 20", 32'(t2 - t1), 32'd20);
        reg_write(REG_CTRL, 8'h00, "ctrl off");
        reg_write(REG_STATUS, 8'h03, "w1c all");
        reg_read(REG_STATUS, 8'h00, "status cleared");

        // Both timers pending, then disabled (pending kept)
        reg_write(REG_SEL, 8'h01, "sel1");
        reg_write(REG_RELOAD_LO, 8'd7, "rl t1 7");
        reg_write(REG_SEL, 8'h00, "sel0 b");
        reg_write(REG_RELOAD_LO, 8'd5, "rl t0 5");
        reg_write(REG_CTRL, 8'h03, "ctrl both");
        repeat (30) @(negedge CLK);
        reg_write(REG_CTRL, 8'h00, "ctrl freeze");
        reg_read(REG_STATUS, 8'h03, "status both");

        // Level 7 peripheral over timer level; no autovector at level 7 or 3
        IRQ_n = 7'b0111111;
        repeat (2) @(negedge CLK);
        check("ipl level7", 32'(IPL_n), 32'(3'b000));
        iack(3'd7, 1'b0, "iack7 no avec");
        iack(3'd3, 1'b0, "iack3 no avec");
        reg_read(REG_STATUS, 8'h03, "status after iack7");
        IRQ_n = 7'h7F;
        repeat (2) @(negedge CLK);
        check("ipl back to 6", 32'(IPL_n), 32'(3'b001));

        iack(3'd6, 1'b1, "iack6 first");
        reg_read(REG_STATUS, 8'h02, "status lowest cleared");
        check("ipl stays 6", 32'(IPL_n), 32'(3'b001));
        iack(3'd6, 1'b1, "iack6 second");
        reg_read(REG_STATUS, 8'h00, "status none");
        repeat (2) @(negedge CLK);
        check("ipl idle", 32'(IPL_n), 32'(3'b111));

        // W1C landing on the fire edge: fire wins
        reg_write(REG_RELOAD_LO, 8'd10, "rl t0 10");
        reg_write(REG_CTRL, 8'h01, "ctrl t0 b");
        wait_ipl(3'b001, 40, "fire10 ipl", f);
        reg_write(REG_STATUS, 8'h01, "w1c normal");
        reg_read(REG_STATUS, 8'h00, "w1c cleared");
        while (cyc < f + 7) @(negedge CLK);
        reg_write(REG_STATUS, 8'h01, "w1c on fire");
        reg_read(REG_STATUS, 8'h01, "fire wins");
        reg_write(REG_CTRL, 8'h00, "ctrl off b");
        reg_write(REG_STATUS, 8'h03, "w1c all b");

        // RELOAD=0 never fires
        reg_write(REG_SEL, 8'h01, "sel1 b");
        reg_write(REG_RELOAD_LO, 8'h00, "rl t1 0");
        reg_write(REG_CTRL, 8'h02, "ctrl t1");
        repeat (100) @(negedge CLK);
        reg_read(REG_STATUS, 8'h00, "reload0 no fire");
        check("reload0 ipl", 32'(IPL_n), 32'(3'b111));
        reg_write(REG_CTRL, 8'h00, "ctrl off c");

        // Bus watchdog on an unacknowledged cycle
        @(negedge CLK);
        CS_n = 1'b1; FC = 3'b101; AS_n = 1'b0;
        c0 = cyc;
`ifdef BUS_WATCHDOG_EN
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (!BERR_n) begin
                seen = 1'b1;
                break;
            end
        end
        check("berr seen", 32'(seen), 32'd1);
        check("berr at 16", 32'(cyc - c0), 32'd16);
        repeat (3) @(negedge CLK);
        check("berr held", 32'(BERR_n), 32'd0);
        AS_n = 1'b1;
        @(negedge CLK);
        check("berr released", 32'(BERR_n), 32'd1);
        reg_read(REG_STATUS, 8'h80, "status berr flag");
        reg_write(REG_STATUS, 8'h80, "w1c berr");
        reg_read(REG_STATUS, 8'h00, "berr flag cleared");
`else
        seen = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (!BERR_n) seen = 1'b1;
        end
        check("berr never", 32'(seen), 32'd0);
        check("hold length", 32'(cyc - c0), 32'd40);
        AS_n = 1'b1;
        reg_read(REG_STATUS, 8'h00, "status no berr flag");
`endif

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
